// File: rtl/hilo_mdu_writer.sv
// Multi-cycle MULT/DIV unit driving the single HI/LO write port, LO first then HI.
// Optional MDU_FAST_MULT_EN: single-cycle multiply instead of 32-step shift-add.
module hilo_mdu_writer #(
  parameter int   XLEN    = 32,
  parameter logic LO_ADDR = 1'b0,
  parameter logic HI_ADDR = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic            hl_wen,
  output logic            hl_waddr,
  output logic [XLEN-1:0] hl_wdata
);
  localparam logic [2:0] OP_MULT = 3'd0, OP_DIV = 3'd2, OP_MTHI = 3'd4, OP_MTLO = 3'd5;
  localparam logic [5:0] CNT_LAST = 6'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, WR_LO, WR_HI} state_t;
  state_t state, state_d;

  logic [2*XLEN-1:0] acc, step, fixed, mul_step, div_step;
  logic [XLEN-1:0]   bmag, a_mag, b_mag, lo_imm;
  logic [5:0]        cnt;
  logic              is_div, neg_q, neg_r, lo_only;
  logic              accept, sgn, a_neg, b_neg;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic              wen_d, waddr_d, done_d;
  logic [XLEN-1:0]   wdata_d;

  assign busy   = (state != IDLE);
  assign accept = start && !busy && !(op[2] && op[1]);
  assign sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg  = sgn && src_a[XLEN-1];
  assign b_neg  = sgn && src_b[XLEN-1];
  assign a_mag  = a_neg ? -src_a : src_a;
  assign b_mag  = b_neg ? -src_b : src_b;

  // One shift-add multiply step: acc = {partial product, remaining multiplier}
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, bmag} : '0);
  assign mul_step = {mul_sum, acc[XLEN-1:1]};
  // One restoring divide step: acc = {remainder, dividend/quotient}
  assign rem_sh   = acc[2*XLEN-1:XLEN-1];
  assign div_step = (rem_sh >= {1'b0, bmag}) ?
                    {rem_sh[XLEN-1:0] - bmag, acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
  assign step     = is_div ? div_step : mul_step;
  assign fixed    = is_div ? {neg_r ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN],
                              neg_q ? -step[XLEN-1:0]      : step[XLEN-1:0]}
                           : (neg_q ? -step : step);

`ifdef MDU_FAST_MULT_EN
  logic [2*XLEN-1:0] prod_m, prod_s;
  assign prod_m = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign prod_s = (a_neg ^ b_neg) ? -prod_m : prod_m;
  assign lo_imm = (op == OP_MTLO) ? src_a : prod_s[XLEN-1:0];
`else
  assign lo_imm = src_a;
`endif

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) begin
        case (op)
          OP_MTHI: state_d = WR_HI;
          OP_MTLO: state_d = WR_LO;
`ifdef MDU_FAST_MULT_EN
          default: state_d = op[1] ? CALC : WR_LO;
`else
          default: state_d = CALC;
`endif
        endcase
      end
      CALC:    if (cnt == CNT_LAST) state_d = WR_LO;
      WR_LO:   state_d = lo_only ? IDLE : WR_HI;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the coming state, registered below
  always_comb begin
    wen_d   = 1'b0;
    waddr_d = hl_waddr;
    wdata_d = hl_wdata;
    done_d  = 1'b0;
    case (state_d)
      WR_LO: begin
        wen_d   = 1'b1;
        waddr_d = LO_ADDR;
        wdata_d = (state == CALC) ? fixed[XLEN-1:0] : lo_imm;
        done_d  = (state == IDLE) && (op == OP_MTLO);
      end
      WR_HI: begin
        wen_d   = 1'b1;
        waddr_d = HI_ADDR;
        wdata_d = (state == WR_LO) ? acc[2*XLEN-1:XLEN] : src_a;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      hl_wen   <= 1'b0;
      hl_waddr <= 1'b0;
      hl_wdata <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      hl_wen   <= wen_d;
      hl_waddr <= waddr_d;
      hl_wdata <= wdata_d;
      done     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt     <= '0;
      acc     <= '0;
      bmag    <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      lo_only <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      bmag    <= b_mag;
      is_div  <= op[1];
      // Divide by zero keeps the quotient all ones regardless of operand signs
      neg_q   <= (a_neg ^ b_neg) && (|src_b);
      neg_r   <= a_neg;
      lo_only <= (op == OP_MTLO);
`ifdef MDU_FAST_MULT_EN
      acc     <= op[1] ? {{XLEN{1'b0}}, a_mag} : prod_s;
`else
      acc     <= {{XLEN{1'b0}}, a_mag};
`endif
    end else if (state == CALC) begin
      cnt <= cnt + 6'd1;
      acc <= (cnt == CNT_LAST) ? fixed : step;
    end
  end
endmodule

// File: tb/tb_hilo_mdu_writer.sv
// Directed scoreboard bench for hilo_mdu_writer; honours MDU_FAST_MULT_EN for multiply latency.
module tb_hilo_mdu_writer;
  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done, hl_wen, hl_waddr;
  logic [31:0] hl_wdata;

  hilo_mdu_writer dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hl_wen(hl_wen), .hl_waddr(hl_waddr), .hl_wdata(hl_wdata)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LO = 1, MUL_HI = 2, MUL_BUSY = 2;
`else
  localparam int MUL_LO = 33, MUL_HI = 34, MUL_BUSY = 34;
`endif

  typedef struct {
    logic        addr;
    logic [31:0] data;
    logic        dn;
    int          edge_n;
  } wr_t;
  wr_t sb[$];
  int compared = 0, mism = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance to the next falling edge and check the write port against the scoreboard
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (rstn) begin
      if (hl_wen) begin
        chk("write_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("waddr", 64'(hl_waddr), 64'(e.addr));
          chk("wdata", 64'(hl_wdata), 64'(e.data));
          chk("done_on_write", 64'(done), 64'(e.dn));
          chk("write_edge", 64'(cyc + 1), 64'(e.edge_n));
        end
      end else begin
        chk("done_without_write", 64'(done), 64'd0);
      end
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    logic [63:0] res;
    sa = longint'(signed'(a));
    sb_ = longint'(signed'(b));
    res = '0;
    case (o)
      3'd0: res = sa * sb_;
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin q = sa / sb_; r = sa % sb_; res = {r[31:0], q[31:0]}; end
      3'd3: if (b == 0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic wr_t mk(input logic ad, input logic [31:0] d, input logic dn, input int en);
    wr_t w;
    w.addr = ad; w.data = d; w.dn = dn; w.edge_n = en;
    return w;
  endfunction

  // Push the expected writes for one op accepted at the next posedge
  task automatic expect_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int t;
    r = ref_res(o, a, b);
    t = cyc + 1;
    case (o)
      3'd4: sb.push_back(mk(1'b1, a, 1'b1, t + 1));
      3'd5: sb.push_back(mk(1'b0, a, 1'b1, t + 1));
      3'd0, 3'd1: begin
        sb.push_back(mk(1'b0, r[31:0], 1'b0, t + MUL_LO));
        sb.push_back(mk(1'b1, r[63:32], 1'b1, t + MUL_HI));
      end
      default: begin
        sb.push_back(mk(1'b0, r[31:0], 1'b0, t + 33));
        sb.push_back(mk(1'b1, r[63:32], 1'b1, t + 34));
      end
    endcase
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int bc, eb;
    expect_op(o, a, b);
    eb = (o >= 3'd4) ? 1 : (o <= 3'd1) ? MUL_BUSY : 34;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (busy) bc++;
      else break;
    end
    chk("busy_cycles", 64'(bc), 64'(eb));
    chk("drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy) break;
    end
    chk("drained", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wen", 64'(hl_wen), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_waddr", 64'(hl_waddr), 64'd0);
    chk("rst_wdata", 64'(hl_wdata), 64'd0);
    rstn = 1'b1;
    tick();

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);          // MULT -2 x 3
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  // MULTU max x max
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);  // MULT min x min
    issue(3'd0, 32'h0001_2345, 32'hFFFF_0000);  // MULT pos x neg
    issue(3'd3, 32'd100, 32'd7);                // DIVU 100/7
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);          // DIV -7/2
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);          // DIV 7/-2
    issue(3'd2, 32'd5, 32'd0);                  // DIV 5/0
    issue(3'd2, 32'hFFFF_FFFB, 32'd0);          // DIV -5/0
    issue(3'd3, 32'hFFFF_FFFF, 32'd0);          // DIVU by zero
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);  // overflow case wraps
    issue(3'd3, 32'hDEAD_BEEF, 32'h0000_1234);
    issue(3'd4, 32'h1234_5678, 32'h0);          // MTHI
    issue(3'd5, 32'hCAFE_F00D, 32'h0);          // MTLO

    // Invalid op is ignored
    op = 3'd6; src_a = 32'h5555_5555; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("invalid_busy", 64'(busy), 64'd0);

    // Start while busy is ignored
    expect_op(3'd3, 32'd1000, 32'd3);
    op = 3'd3; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) tick();
    op = 3'd4; src_a = 32'hDEAD_0000; start = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // Reset mid-divide aborts with no write
    op = 3'd3; src_a = 32'd99; src_b = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) tick();
    rstn = 1'b0;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wen", 64'(hl_wen), 64'd0);
    chk("abort_wdata", 64'(hl_wdata), 64'd0);
    rstn = 1'b1;
    repeat (40) tick();
    chk("abort_busy_after", 64'(busy), 64'd0);

    issue(3'd0, 32'd6, 32'hFFFF_FFF9);          // recovery after abort
    issue(3'd2, 32'h7FFF_FFFF, 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
